// File: rtl/pid_mc_if.sv
// Sample, coefficient and result bundle for the multi-channel PID controller.
// The master side is the front-end/config host; the slave side is pid_mc.
interface pid_mc_if #(
   parameter int D_WIDTH = 18,
   parameter int N_CH    = 4
);
   localparam int CH_W = $clog2(N_CH);

   logic                      cfg_we;
   logic [CH_W-1:0]           cfg_ch;
   logic [1:0]                cfg_sel;
   logic signed [D_WIDTH-1:0] cfg_data;
   logic                      clr_ch_we;
   logic [CH_W-1:0]           clr_ch;
   logic                      in_valid;
   logic                      in_ready;
   logic [CH_W-1:0]           in_ch;
   logic signed [D_WIDTH-1:0] in_target;
   logic signed [D_WIDTH-1:0] in_meas;
   logic                      out_valid;
   logic [CH_W-1:0]           out_ch;
   logic signed [D_WIDTH-1:0] out_data;
   logic                      busy;

   modport master (
      output cfg_we, cfg_ch, cfg_sel, cfg_data, clr_ch_we, clr_ch,
             in_valid, in_ch, in_target, in_meas,
      input  in_ready, out_valid, out_ch, out_data, busy
   );

   modport slave (
      input  cfg_we, cfg_ch, cfg_sel, cfg_data, clr_ch_we, clr_ch,
             in_valid, in_ch, in_target, in_meas,
      output in_ready, out_valid, out_ch, out_data, busy
   );
endinterface

// File: rtl/pid_mc.sv
// Time-multiplexed N-channel fixed-point PID controller sharing one signed multiplier.
// Each sample walks P, I, D1, D2 multiplies, then clamps, outputs and writes loop state back.
module pid_mc #(
   parameter int D_WIDTH = 18,
   parameter int Q_BITS  = 15,
   parameter int N_CH    = 4,
   parameter int LIM_MAX = 4096,
   parameter int LIM_MIN = -4096
) (
   input logic     clock,
   input logic     reset,
   pid_mc_if.slave bus
);
   localparam int CH_W = $clog2(N_CH);
   localparam int PW   = 2 * D_WIDTH + 1;
   localparam int SW   = D_WIDTH + 2;
   localparam logic signed [PW-1:0] DMAX = PW'((1 <<< (D_WIDTH - 1)) - 1);
   localparam logic signed [PW-1:0] DMIN = PW'(-(1 <<< (D_WIDTH - 1)));
   localparam logic signed [SW-1:0] LMAX = SW'(LIM_MAX);
   localparam logic signed [SW-1:0] LMIN = SW'(LIM_MIN);

   typedef enum logic [2:0] {IDLE, MUL_P, MUL_I, MUL_D1, MUL_D2, DONE} state_t;
   state_t state_q, state_d;

   logic signed [D_WIDTH-1:0] kp_q [N_CH];
   logic signed [D_WIDTH-1:0] ki_q [N_CH];
   logic signed [D_WIDTH-1:0] kd1_q [N_CH];
   logic signed [D_WIDTH-1:0] kd2_q [N_CH];
   logic signed [D_WIDTH-1:0] iAcc_q [N_CH];
   logic signed [D_WIDTH-1:0] prevE_q [N_CH];
   logic signed [D_WIDTH-1:0] prevD_q [N_CH];

   logic [CH_W-1:0]           ch_q;
   logic signed [D_WIDTH-1:0] e_q, kpS_q, kiS_q, kd1S_q, kd2S_q;
   logic signed [D_WIDTH-1:0] iAccS_q, prevES_q, prevDS_q;
   logic signed [D_WIDTH-1:0] p_q, iTerm_q, d1_q, d_q;
   logic                      clrHit_q;
   logic                      outValid_q;
   logic [CH_W-1:0]           outCh_q;
   logic signed [D_WIDTH-1:0] outData_q;

   logic                      accept;
   logic signed [D_WIDTH:0]   errWide;
   logic signed [D_WIDTH-1:0] mulA, mulSat;
   logic signed [D_WIDTH:0]   mulB;
   logic signed [PW-1:0]      prod, prodSh;
   logic signed [SW-1:0]      pW, iSum, hiLim, loLim, iClamp, outSum;
   logic signed [D_WIDTH-1:0] iNew, outClamp;
   logic                      wbEn;

   function automatic logic signed [D_WIDTH-1:0] satD(input logic signed [PW-1:0] v);
      if (v > DMAX) return DMAX[D_WIDTH-1:0];
      if (v < DMIN) return DMIN[D_WIDTH-1:0];
      return v[D_WIDTH-1:0];
   endfunction

   assign accept        = bus.in_valid && (state_q == IDLE);
   assign errWide       = (D_WIDTH+1)'(bus.in_target) - (D_WIDTH+1)'(bus.in_meas);
   assign bus.in_ready  = (state_q == IDLE);
   assign bus.busy      = (state_q != IDLE);
   assign bus.out_valid = outValid_q;
   assign bus.out_ch    = outCh_q;
   assign bus.out_data  = outData_q;

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = MUL_P;
         MUL_P:   state_d = MUL_I;
         MUL_I:   state_d = MUL_D1;
         MUL_D1:  state_d = MUL_D2;
         MUL_D2:  state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // The single multiplier: operands are steered by the current phase.
   always_comb begin
      mulA = kpS_q;
      mulB = (D_WIDTH+1)'(e_q);
      case (state_q)
         MUL_I: begin
            mulA = kiS_q;
            mulB = (D_WIDTH+1)'(e_q) + (D_WIDTH+1)'(prevES_q);
         end
         MUL_D1: begin
            mulA = kd1S_q;
            mulB = (D_WIDTH+1)'(e_q) - (D_WIDTH+1)'(prevES_q);
         end
         MUL_D2: begin
            mulA = kd2S_q;
            mulB = (D_WIDTH+1)'(prevDS_q);
         end
         default: ;
      endcase
      prod   = mulA * mulB;
      prodSh = prod >>> Q_BITS;
      mulSat = satD(prodSh);
   end

   // Anti-windup window tracks the headroom the proportional term leaves.
   always_comb begin
      pW     = SW'(p_q);
      iSum   = SW'(iAccS_q) + SW'(iTerm_q);
      hiLim  = LMAX - pW;
      loLim  = LMIN - pW;
      if (hiLim[SW-1]) hiLim = '0;
      if (!loLim[SW-1]) loLim = '0;
      iClamp = iSum;
      if (iSum > hiLim) iClamp = hiLim;
      else if (iSum < loLim) iClamp = loLim;
      iNew   = satD(PW'(iClamp));
      outSum = pW + SW'(iNew) + SW'(d_q);
      outClamp = outSum[D_WIDTH-1:0];
      if (outSum > LMAX) outClamp = LMAX[D_WIDTH-1:0];
      else if (outSum < LMIN) outClamp = LMIN[D_WIDTH-1:0];
      wbEn   = (state_q == DONE) && !clrHit_q;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         ch_q       <= '0;
         e_q        <= '0;
         kpS_q      <= '0;
         kiS_q      <= '0;
         kd1S_q     <= '0;
         kd2S_q     <= '0;
         iAccS_q    <= '0;
         prevES_q   <= '0;
         prevDS_q   <= '0;
         p_q        <= '0;
         iTerm_q    <= '0;
         d1_q       <= '0;
         d_q        <= '0;
         clrHit_q   <= 1'b0;
         outValid_q <= 1'b0;
         outCh_q    <= '0;
         outData_q  <= '0;
      end else begin
         state_q    <= state_d;
         outValid_q <= 1'b0;
         if (accept) begin
            ch_q     <= bus.in_ch;
            e_q      <= satD(PW'(errWide));
            kpS_q    <= kp_q[bus.in_ch];
            kiS_q    <= ki_q[bus.in_ch];
            kd1S_q   <= kd1_q[bus.in_ch];
            kd2S_q   <= kd2_q[bus.in_ch];
            iAccS_q  <= iAcc_q[bus.in_ch];
            prevES_q <= prevE_q[bus.in_ch];
            prevDS_q <= prevD_q[bus.in_ch];
            clrHit_q <= bus.clr_ch_we && (bus.clr_ch == bus.in_ch);
         end else if (bus.clr_ch_we && (bus.clr_ch == ch_q)) begin
            clrHit_q <= 1'b1;
         end
         case (state_q)
            MUL_P:  p_q     <= mulSat;
            MUL_I:  iTerm_q <= mulSat;
            MUL_D1: d1_q    <= mulSat;
            MUL_D2: d_q     <= satD(PW'(d1_q) + PW'(mulSat));
            DONE: begin
               outValid_q <= 1'b1;
               outCh_q    <= ch_q;
               outData_q  <= outClamp;
            end
            default: ;
         endcase
      end
   end

   // A clear on the same edge as write-back to that channel wins.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int c = 0; c < N_CH; c++) begin
            kp_q[c]    <= '0;
            ki_q[c]    <= '0;
            kd1_q[c]   <= '0;
            kd2_q[c]   <= '0;
            iAcc_q[c]  <= '0;
            prevE_q[c] <= '0;
            prevD_q[c] <= '0;
         end
      end else begin
         for (int c = 0; c < N_CH; c++) begin
            if (bus.cfg_we && (bus.cfg_ch == CH_W'(c))) begin
               case (bus.cfg_sel)
                  2'd0:    kp_q[c]  <= bus.cfg_data;
                  2'd1:    ki_q[c]  <= bus.cfg_data;
                  2'd2:    kd1_q[c] <= bus.cfg_data;
                  default: kd2_q[c] <= bus.cfg_data;
               endcase
            end
            if (bus.clr_ch_we && (bus.clr_ch == CH_W'(c))) begin
               iAcc_q[c]  <= '0;
               prevE_q[c] <= '0;
               prevD_q[c] <= '0;
            end else if (wbEn && (ch_q == CH_W'(c))) begin
               iAcc_q[c]  <= iNew;
               prevE_q[c] <= e_q;
               prevD_q[c] <= d_q;
            end
         end
      end
   end
endmodule
